// File: rtl/bridge_dead_time_pkg.sv
// Shared types and gate encodings for the H-bridge dead-time stage.
package bridge_dead_time_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDriveP,
        StDriveN,
        StDead,
        StFault
    } state_e;

    typedef enum logic [1:0] {
        ReqNone,
        ReqP,
        ReqN,
        ReqC
    } req_e;

    // Gate vectors ordered {ha, la, hb, lb}
    localparam logic [3:0] GatesOff = 4'b0000;
    localparam logic [3:0] GatesP   = 4'b1001;
    localparam logic [3:0] GatesN   = 4'b0110;

    // Only the two drive states ever turn a switch on; each closes one diagonal.
    function automatic logic [3:0] gates_of(input state_e s);
        case (s)
            StDriveP: return GatesP;
            StDriveN: return GatesN;
            default:  return GatesOff;
        endcase
    endfunction

endpackage

// File: rtl/bridge_dead_time.sv
// Break-before-make H-bridge gate sequencer with enable gating and
// shoot-through fault latching.
module bridge_dead_time
    import bridge_dead_time_pkg::*;
#(
    parameter int unsigned DEAD_CYCLES   = 10,
    parameter int unsigned FAULT_CNT_MAX = 255
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 en,
    input  logic                                 in_p,
    input  logic                                 in_n,
    output logic                                 gate_ha,
    output logic                                 gate_la,
    output logic                                 gate_hb,
    output logic                                 gate_lb,
    output logic                                 fault,
    output logic [$clog2(FAULT_CNT_MAX+1)-1:0]   fault_cnt
);

    localparam int unsigned CntW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam int unsigned FcW  = $clog2(FAULT_CNT_MAX + 1);
    localparam logic [CntW-1:0] CntReload = CntW'(DEAD_CYCLES - 1);
    localparam logic [FcW-1:0]  FcMax     = FcW'(FAULT_CNT_MAX);

    // Both requests at once is a shoot-through request regardless of enable.
    function automatic req_e decode(input logic e, input logic p, input logic n);
        if (p && n)      return ReqC;
        else if (e && p) return ReqP;
        else if (e && n) return ReqN;
        else             return ReqNone;
    endfunction

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    req_e            req;

    assign req = decode(en, in_p, in_n);

    // Next state and dead counter; every drive exit funnels through StDead.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                case (req)
                    ReqP:    state_d = StDriveP;
                    ReqN:    state_d = StDriveN;
                    ReqC:    state_d = StFault;
                    default: state_d = StIdle;
                endcase
            end
            StDriveP: begin
                if (req == ReqC) begin
                    state_d = StFault;
                end else if (req != ReqP) begin
                    state_d = StDead;
                    cnt_d   = CntReload;
                end
            end
            StDriveN: begin
                if (req == ReqC) begin
                    state_d = StFault;
                end else if (req != ReqN) begin
                    state_d = StDead;
                    cnt_d   = CntReload;
                end
            end
            StDead: begin
                if (req == ReqC) begin
                    state_d = StFault;
                end else if (cnt_q == '0) begin
                    // Only the request present on the final dead cycle is honoured
                    case (req)
                        ReqP:    state_d = StDriveP;
                        ReqN:    state_d = StDriveN;
                        default: state_d = StIdle;
                    endcase
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StFault: begin
                if (!in_p && !in_n) begin
                    state_d = StDead;
                    cnt_d   = CntReload;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, counter and outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            gate_ha   <= 1'b0;
            gate_la   <= 1'b0;
            gate_hb   <= 1'b0;
            gate_lb   <= 1'b0;
            fault     <= 1'b0;
            fault_cnt <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            {gate_ha, gate_la, gate_hb, gate_lb} <= gates_of(state_d);
            fault   <= (state_d == StFault);
            if (state_d == StFault && state_q != StFault && fault_cnt != FcMax) begin
                fault_cnt <= fault_cnt + FcW'(1);
            end
        end
    end

endmodule
